demux1x4_dispatch: RTL and testbench
====================================

# demux1x4_dispatch

Routes a stream of 10-bit words from one upstream source to one of four downstream destinations, using the word's class field as the destination index. It is the egress counterpart of the 4:1 round-robin arbitration mux: the arbiter merges four class queues into one stream, and this block splits one stream back into four. Each destination has a one-entry output holding register with a valid/ready handshake, so a stalled destination blocks only words addressed to it.

## Interface
- `DW`, default 10: word width. Must be ≥ 3.
- `SEL_MSB`, default 9: MSB of the 2-bit destination field, which is `in_data[SEL_MSB:SEL_MSB-1]`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Asserts immediately on `reset=0`; release is synchronized externally.
- `in_valid`, input, 1: upstream offers `in_data` this cycle.
- `in_data`, input, DW: word; destination field as defined by `SEL_MSB`.
- `in_ready`, output, 1: block accepts `in_data` this cycle.
- `out_valid`, output, 4: bit i set means `out_data_i` holds a word for destination i.
- `out_ready`, input, 4: bit i set means destination i consumes `out_data_i` this cycle.
- `out_data_0` .. `out_data_3`, output, DW each: holding registers; full word including the destination field.
- `word_cnt_0` .. `word_cnt_3`, output, 8 each: only present with `DEMUX_CNT_EN`; words delivered per destination.

## Operation
- Destination: `d = in_data[SEL_MSB:SEL_MSB-1]`.
- Accept condition: `accept = in_valid & in_ready`.
- `in_ready = ~out_valid[d] | out_ready[d]`.
  - Combinational from `in_data` and `out_ready`; no combinational path from `in_valid`.
- Holding register i, per rising edge, in priority order:
  - load: `accept & (d==i)`. Then `out_data_i <= in_data` and `out_valid[i] <= 1`.
  - drain only: `out_valid[i] & out_ready[i]` with no load. Then `out_valid[i] <= 0`; `out_data_i` keeps its old value.
  - otherwise: hold.
- Drain and load in the same cycle: the register stays valid and takes the new word. No bubble, no loss.
- `out_data_i` is meaningful only while `out_valid[i]=1`.
- At most one word is accepted per cycle. The other three destinations drain independently and concurrently.
- `out_ready[i]` with `out_valid[i]=0` has no effect.
- Ordering: words to the same destination leave in arrival order. There is no ordering across destinations.
- Words are never dropped or duplicated.

## Timing
- Reset (`reset=0`, asynchronous):
  - `out_valid=4'b0000`.
  - `out_data_0..3` = 0.
  - `word_cnt_*` = 0.
  - `in_ready` then follows its combinational formula and equals 1.
- Reset mid-operation discards all held words. No handshake completes in a cycle where reset is asserted.
- Latency: a word accepted at edge N appears with `out_valid[d]=1` after edge N. It can be consumed at edge N+1 at the earliest.
- Throughput: one word per cycle sustained when `out_ready[d]=1`, including back-to-back words to the same destination.
- Stall: when `out_valid[d]=1` and `out_ready[d]=0`, `in_ready=0`. Upstream must keep `in_valid` and `in_data` stable until accepted.

## Configuration
- `DEMUX_CNT_EN` defined:
  - Adds `word_cnt_0..3`.
  - `word_cnt_i` increments on each edge where `out_valid[i] & out_ready[i]`.
  - 8-bit wrap-around: 255 → 0.
  - Reset to 0.
- `DEMUX_CNT_EN` undefined:
  - Ports and counter logic are absent.
  - Routing behaviour is identical.

## Test plan
- Reset, then stimulus. During `reset=0`, check `out_valid=0`, all `out_data_*=0`, `in_ready=1`. Then stream `10'h012, 10'h134, 10'h256, 10'h378` with `out_ready=4'hF`: one word per cycle appears on destinations 0, 1, 2, 3 respectively, each one cycle after acceptance.
- Back-to-back, one destination: `10'h101, 10'h102, 10'h103` with `out_ready[1]=1` continuously. Expect `out_data_1` = 101, 102, 103 on consecutive cycles, `in_ready` held at 1, no gaps.
- Stall isolation:
  - Hold `out_ready[2]=0`. Send `10'h2AA` (accepted), then `10'h2BB`: `in_ready=0`, and `10'h2BB` is held off.
  - Switch `in_data` to `10'h0CC`: it is accepted and delivered on destination 0.
  - Release `out_ready[2]`: 2AA drains, then 2BB is accepted.
- Simultaneous drain and load: `out_valid[3]=1` with `10'h3F0`, `out_ready[3]=1`, and offer `10'h3F1` in the same cycle. Expect accept, `out_valid[3]` stays 1, `out_data_3=10'h3F1`.
- Asynchronous reset mid-stall: with destinations 1 and 2 holding words, pulse `reset=0` between clock edges. Outputs clear immediately, and no held word appears after release.
- With `DEMUX_CNT_EN`: deliver 257 words to destination 0. Expect `word_cnt_0=1` and the other counters at 0.

Source files
------------

// File: rtl/demux1x4_dispatch.sv
// ---------------------------------------------------------------------------
// demux1x4_dispatch
//
// Splits one valid/ready stream of DW-bit words into four destination
// streams. The 2-bit field in_data[SEL_MSB:SEL_MSB-1] selects the
// destination. Each destination owns a one-entry holding register, so a
// stalled destination only blocks words that are addressed to it.
//
// Parameters:
//   DW          word width (>= 3)
//   SEL_MSB     MSB of the 2-bit destination field inside in_data
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   in_valid    upstream offers in_data this cycle
//   in_data     word, carries its own destination field
//   in_ready    block accepts in_data this cycle
//   out_valid   bit i set: out_data_i holds a word for destination i
//   out_ready   bit i set: destination i consumes out_data_i this cycle
//   out_data_0..3   holding registers (full word, field included)
//   word_cnt_0..3   words delivered per destination, 8-bit wrapping
//                   (present only when DEMUX_CNT_EN is defined)
//
// Build option:
//   DEMUX_CNT_EN    adds the per-destination delivery counters
// ---------------------------------------------------------------------------
module demux1x4_dispatch #(
    parameter int DW      = 10,
    parameter int SEL_MSB = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
`ifdef DEMUX_CNT_EN
    output logic [7:0]    word_cnt_0,
    output logic [7:0]    word_cnt_1,
    output logic [7:0]    word_cnt_2,
    output logic [7:0]    word_cnt_3,
`endif
    output logic [DW-1:0] out_data_0,
    output logic [DW-1:0] out_data_1,
    output logic [DW-1:0] out_data_2,
    output logic [DW-1:0] out_data_3
);

    logic [1:0]    dest;
    logic          accept;
    logic [3:0]    load;
    logic [3:0]    drain;
    logic [DW-1:0] data_q [4];

    assign dest = in_data[SEL_MSB -: 2];

    // The addressed slot can take a word when it is empty or is being
    // emptied in this same cycle; in_valid deliberately plays no part in
    // in_ready so upstream never sees a combinational loop through it.
    always_comb begin
        in_ready = ~out_valid[dest] | out_ready[dest];
        accept   = in_valid & in_ready;
        load     = 4'b0000;
        if (accept) begin
            load[dest] = 1'b1;
        end
        drain    = out_valid & out_ready;
    end

    // Holding registers. A load wins over a drain, which gives the
    // bubble-free drain-and-refill case for free: the slot stays valid and
    // simply takes the new word. A drain alone leaves the data untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i]    <= in_data;
                    out_valid[i] <= 1'b1;
                end else if (drain[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign out_data_0 = data_q[0];
    assign out_data_1 = data_q[1];
    assign out_data_2 = data_q[2];
    assign out_data_3 = data_q[3];

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt_q [4];

    // Delivery counters advance on each completed downstream handshake and
    // wrap naturally at 8 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (drain[i]) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign word_cnt_0 = cnt_q[0];
    assign word_cnt_1 = cnt_q[1];
    assign word_cnt_2 = cnt_q[2];
    assign word_cnt_3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux1x4_dispatch.sv
// ---------------------------------------------------------------------------
// tb_demux1x4_dispatch
//
// Self-checking bench for demux1x4_dispatch. A reference model keeps one
// queue of pending words per destination (a destination accepts a new word
// only when its queue is empty or its head leaves in the same cycle) and a
// delivery count per destination. Directed scenarios are followed by a
// randomized run that respects the upstream hold-until-accepted rule.
// DEMUX_CNT_EN enables the counter checks.
// ---------------------------------------------------------------------------
module tb_demux1x4_dispatch;

    localparam int DW      = 10;
    localparam int SEL_MSB = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [DW-1:0] out_data_0, out_data_1, out_data_2, out_data_3;
    logic [DW-1:0] obs_data [4];
`ifdef DEMUX_CNT_EN
    logic [7:0]    word_cnt_0, word_cnt_1, word_cnt_2, word_cnt_3;
    logic [7:0]    obs_cnt [4];
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [DW-1:0] mq [4][$];
    logic [7:0]    mcnt [4];

    demux1x4_dispatch #(.DW(DW), .SEL_MSB(SEL_MSB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef DEMUX_CNT_EN
        .word_cnt_0 (word_cnt_0),
        .word_cnt_1 (word_cnt_1),
        .word_cnt_2 (word_cnt_2),
        .word_cnt_3 (word_cnt_3),
`endif
        .out_data_0 (out_data_0),
        .out_data_1 (out_data_1),
        .out_data_2 (out_data_2),
        .out_data_3 (out_data_3)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Gather the per-destination outputs into arrays for looped checks
    assign obs_data[0] = out_data_0;
    assign obs_data[1] = out_data_1;
    assign obs_data[2] = out_data_2;
    assign obs_data[3] = out_data_3;
`ifdef DEMUX_CNT_EN
    assign obs_cnt[0] = word_cnt_0;
    assign obs_cnt[1] = word_cnt_1;
    assign obs_cnt[2] = word_cnt_2;
    assign obs_cnt[3] = word_cnt_3;
`endif

    function automatic logic [1:0] dest_of(input logic [DW-1:0] w);
        return w[SEL_MSB -: 2];
    endfunction

    function automatic logic model_ready();
        logic [1:0] d;
        d = dest_of(in_data);
        return (mq[d].size() == 0) || out_ready[d];
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        v = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            v[i] = (mq[i].size() != 0);
        end
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            mcnt[i] = 8'd0;
        end
    endtask

    // Advance one clock: decide the model transfer from the inputs as they
    // stand before the edge, then move to 1 ns after the edge.
    task automatic tick();
        logic [1:0]    d;
        logic          acc;
        logic [3:0]    rdy;
        logic [DW-1:0] w;
        d   = dest_of(in_data);
        acc = in_valid && model_ready();
        rdy = out_ready;
        w   = in_data;
        @(posedge clk);
        if (!reset) begin
            clear_model();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() != 0 && rdy[i]) begin
                    void'(mq[i].pop_front());
                    mcnt[i] = mcnt[i] + 8'd1;
                end
            end
            if (acc) mq[d].push_back(w);
        end
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'h0;
        clear_model();
        #3;
        compared++;
        if (out_valid !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_valid: got %b want 0000", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (obs_data[i] !== '0) begin
                mismatched++;
                $display("[TB] FAIL reset_data%0d: got %h want 000", i, obs_data[i]);
            end
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
        // An offer while reset is held must not complete
        in_valid  = 1'b1;
        in_data   = 10'h155;
        out_ready = 4'hF;
        tick();
        compared++;
        if (out_valid !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_no_accept: got %b want 0000", out_valid);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [DW-1:0] words [4];
        words     = '{10'h012, 10'h134, 10'h256, 10'h378};
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = words[k];
            #1;
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL stream_ready%0d: got %b want 1", k, in_ready);
            end
            tick();
            compared++;
            if (out_valid !== (4'b0001 << k)) begin
                mismatched++;
                $display("[TB] FAIL stream_valid%0d: got %b want %b", k, out_valid, 4'b0001 << k);
            end
            compared++;
            if (obs_data[k] !== words[k]) begin
                mismatched++;
                $display("[TB] FAIL stream_data%0d: got %h want %h", k, obs_data[k], words[k]);
            end
        end
        in_valid = 1'b0;
        tick();
        compared++;
        if (out_valid !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL stream_drained: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w;
        out_ready = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            w        = 10'h101 + DW'(k);
            in_valid = 1'b1;
            in_data  = w;
            #1;
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL b2b_ready%0d: got %b want 1", k, in_ready);
            end
            tick();
            compared++;
            if (out_valid !== 4'b0010 || out_data_1 !== w) begin
                mismatched++;
                $display("[TB] FAIL b2b_out%0d: got v=%b d=%h want v=0010 d=%h", k, out_valid, out_data_1, w);
            end
        end
        in_valid = 1'b0;
        tick();
        compared++;
        if (out_valid !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL b2b_drained: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_stall_isolation();
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = 10'h2AA;
        tick();
        compared++;
        if (out_valid !== 4'b0100 || out_data_2 !== 10'h2AA) begin
            mismatched++;
            $display("[TB] FAIL stall_load: got v=%b d=%h want v=0100 d=2aa", out_valid, out_data_2);
        end
        in_data = 10'h2BB;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL stall_blocked: got %b want 0", in_ready);
        end
        tick();
        compared++;
        if (out_data_2 !== 10'h2AA) begin
            mismatched++;
            $display("[TB] FAIL stall_held: got %h want 2aa", out_data_2);
        end
        in_data = 10'h0CC;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stall_other_ready: got %b want 1", in_ready);
        end
        tick();
        compared++;
        if (out_valid !== 4'b0101 || out_data_0 !== 10'h0CC) begin
            mismatched++;
            $display("[TB] FAIL stall_other_out: got v=%b d=%h want v=0101 d=0cc", out_valid, out_data_0);
        end
        in_data   = 10'h2BB;
        out_ready = 4'b1111;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL stall_release_ready: got %b want 1", in_ready);
        end
        tick();
        compared++;
        if (out_valid !== 4'b0100 || out_data_2 !== 10'h2BB) begin
            mismatched++;
            $display("[TB] FAIL stall_release_out: got v=%b d=%h want v=0100 d=2bb", out_valid, out_data_2);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_drain_and_load();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 10'h3F0;
        tick();
        compared++;
        if (out_valid !== 4'b1000 || out_data_3 !== 10'h3F0) begin
            mismatched++;
            $display("[TB] FAIL dl_first: got v=%b d=%h want v=1000 d=3f0", out_valid, out_data_3);
        end
        out_ready = 4'b1000;
        in_data   = 10'h3F1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL dl_ready: got %b want 1", in_ready);
        end
        tick();
        compared++;
        if (out_valid !== 4'b1000 || out_data_3 !== 10'h3F1) begin
            mismatched++;
            $display("[TB] FAIL dl_second: got v=%b d=%h want v=1000 d=3f1", out_valid, out_data_3);
        end
        in_valid = 1'b0;
        tick();
        compared++;
        if (out_valid !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL dl_drained: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 10'h1AB;
        tick();
        in_data   = 10'h2CD;
        tick();
        in_valid  = 1'b0;
        compared++;
        if (out_valid !== 4'b0110) begin
            mismatched++;
            $display("[TB] FAIL areset_before: got %b want 0110", out_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        clear_model();
        compared++;
        if (out_valid !== 4'b0000 || out_data_1 !== '0 || out_data_2 !== '0) begin
            mismatched++;
            $display("[TB] FAIL areset_clear: got v=%b d1=%h d2=%h want 0000/000/000", out_valid, out_data_1, out_data_2);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL areset_ready: got %b want 1", in_ready);
        end
        #2;
        reset     = 1'b1;
        out_ready = 4'hF;
        tick();
        compared++;
        if (out_valid !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL areset_after: got %b want 0000", out_valid);
        end
    endtask

`ifdef DEMUX_CNT_EN
    task automatic test_counter();
        logic [7:0] want;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        for (int k = 0; k < 257; k++) begin
            in_data = {2'b00, 8'($urandom_range(0, 255))};
            tick();
        end
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            want = (i == 0) ? 8'd1 : 8'd0;
            compared++;
            if (obs_cnt[i] !== want) begin
                mismatched++;
                $display("[TB] FAIL cnt_wrap%0d: got %0d want %0d", i, obs_cnt[i], want);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic held;
        logic acc;
        held = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!held) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = DW'($urandom_range(0, 1023));
            end
            out_ready = 4'($urandom_range(0, 15));
            #1;
            compared++;
            if (in_ready !== model_ready()) begin
                mismatched++;
                $display("[TB] FAIL rnd_ready@%0d: got %b want %b", k, in_ready, model_ready());
            end
            acc  = in_valid && model_ready();
            held = in_valid && !acc;
            tick();
            compared++;
            if (out_valid !== model_valid()) begin
                mismatched++;
                $display("[TB] FAIL rnd_valid@%0d: got %b want %b", k, out_valid, model_valid());
            end
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() != 0) begin
                    compared++;
                    if (obs_data[i] !== mq[i][0]) begin
                        mismatched++;
                        $display("[TB] FAIL rnd_data%0d@%0d: got %h want %h", i, k, obs_data[i], mq[i][0]);
                    end
                end
`ifdef DEMUX_CNT_EN
                compared++;
                if (obs_cnt[i] !== mcnt[i]) begin
                    mismatched++;
                    $display("[TB] FAIL rnd_cnt%0d@%0d: got %0d want %0d", i, k, obs_cnt[i], mcnt[i]);
                end
`endif
            end
        end
        in_valid = 1'b0;
    endtask

    // Run every scenario in order and report
    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_stall_isolation();
        test_drain_and_load();
        test_async_reset();
`ifdef DEMUX_CNT_EN
        test_counter();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a run that never ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
